// File: rtl/regfile_sb.sv
// Eight-entry register file with write-through bypass
// and a pending-write scoreboard that drives the decode stall.
module regfile_sb #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             issue,
  input  logic [2:0]       issue_dst,
  input  logic             dst_valid,
  input  logic [2:0]       src_a,
  input  logic [2:0]       src_b,
  input  logic             use_a,
  input  logic             use_b,
  input  logic             flush,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r4,
  output logic [WIDTH-1:0] r5,
  output logic [WIDTH-1:0] r6,
  output logic [WIDTH-1:0] r7,
  output logic [7:0]       busy,
  output logic             stall
);

  logic [WIDTH-1:0] regs [8];
  logic [7:0] clr;
  logic [7:0] set;
  logic       haz_a;
  logic       haz_b;
  logic       haz_w;
  logic       fire;

  always_comb begin
    clr = 8'h00;
    if (wr_en) clr = 8'h01 << wr_addr;
  end

  // A writeback landing this cycle resolves the hazard it clears
  always_comb begin
    haz_a = use_a && busy[src_a] && !clr[src_a];
    haz_b = use_b && busy[src_b] && !clr[src_b];
    haz_w = dst_valid && busy[issue_dst] && !clr[issue_dst];
    stall = issue && !flush && (haz_a || haz_b || haz_w);
    fire  = issue && !stall && !flush && dst_valid;
    set   = 8'h00;
    if (fire) set = 8'h01 << issue_dst;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int k = 0; k < 8; k++) regs[k] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // New pending write beats a same-cycle clear; flush beats both
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)      busy <= 8'h00;
    else if (flush) busy <= 8'h00;
    else            busy <= (busy & ~clr) | set;
  end

  assign r0 = clr[0] ? wr_data : regs[0];
  assign r1 = clr[1] ? wr_data : regs[1];
  assign r2 = clr[2] ? wr_data : regs[2];
  assign r3 = clr[3] ? wr_data : regs[3];
  assign r4 = clr[4] ? wr_data : regs[4];
  assign r5 = clr[5] ? wr_data : regs[5];
  assign r6 = clr[6] ? wr_data : regs[6];
  assign r7 = clr[7] ? wr_data : regs[7];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: bypass, scoreboard hazards,
// flush priority and asynchronous reset.
module tb_regfile_sb;

  logic        CLK;
  logic        RSTN;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        issue;
  logic [2:0]  issue_dst;
  logic        dst_valid;
  logic [2:0]  src_a;
  logic [2:0]  src_b;
  logic        use_a;
  logic        use_b;
  logic        flush;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [7:0]  busy;
  logic        stall;
  logic [15:0] rv [8];

  int errors = 0;
  int checks = 0;

  regfile_sb #(.WIDTH(16)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue(issue), .issue_dst(issue_dst), .dst_valid(dst_valid),
    .src_a(src_a), .src_b(src_b), .use_a(use_a), .use_b(use_b),
    .flush(flush),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .busy(busy), .stall(stall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_comb begin
    rv[0] = r0; rv[1] = r1; rv[2] = r2; rv[3] = r3;
    rv[4] = r4; rv[5] = r5; rv[6] = r6; rv[7] = r7;
  end

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0;
    issue = 0; issue_dst = 0; dst_valid = 0;
    src_a = 0; src_b = 0; use_a = 0; use_b = 0;
    flush = 0;
  endtask

  task automatic step();
    @(negedge CLK);
    idle();
  endtask

  task automatic do_issue(input logic [2:0] d);
    step();
    issue = 1; dst_valid = 1; issue_dst = d;
  endtask

  initial begin
    idle();
    RSTN = 0;
    repeat (2) @(negedge CLK);
    RSTN = 1;
    #2;
    for (int k = 0; k < 8; k++) check($sformatf("rst_r%0d", k), rv[k], 16'h0000);
    check("rst_busy", {8'h00, busy}, 16'h0000);
    check("rst_stall", {15'd0, stall}, 16'h0000);

    // write r3, bypass then stored value
    step();
    wr_en = 1; wr_addr = 3; wr_data = 16'hBEEF;
    #2;
    check("byp_r3", r3, 16'hBEEF);
    check("byp_r4", r4, 16'h0000);
    step();
    #2;
    check("reg_r3", r3, 16'hBEEF);
    check("reg_r2", r2, 16'h0000);
    check("wr_nobusy", {8'h00, busy}, 16'h0000);

    // RAW on r5
    do_issue(5);
    #2;
    check("iss5_stall", {15'd0, stall}, 16'h0000);
    step();
    issue = 1; src_a = 5; use_a = 1;
    #2;
    check("raw_busy", {8'h00, busy}, 16'h0020);
    check("raw_stall1", {15'd0, stall}, 16'h0001);
    step();
    issue = 1; src_a = 5; use_a = 1;
    #2;
    check("raw_stall2", {15'd0, stall}, 16'h0001);
    step();
    issue = 1; src_a = 5; use_a = 1;
    wr_en = 1; wr_addr = 5; wr_data = 16'h1234;
    #2;
    check("raw_release", {15'd0, stall}, 16'h0000);
    check("raw_r5", r5, 16'h1234);
    step();
    #2;
    check("raw_busy_clr", {8'h00, busy}, 16'h0000);
    check("raw_r5_reg", r5, 16'h1234);

    // WAW with same-cycle writeback: new pending write wins
    do_issue(2);
    step();
    issue = 1; dst_valid = 1; issue_dst = 2;
    wr_en = 1; wr_addr = 2; wr_data = 16'h5A5A;
    #2;
    check("waw_busy_pre", {8'h00, busy}, 16'h0004);
    check("waw_stall", {15'd0, stall}, 16'h0000);
    check("waw_r2", r2, 16'h5A5A);
    step();
    #2;
    check("waw_busy", {8'h00, busy}, 16'h0004);

    // WAW without writeback stalls, operand B path
    step();
    issue = 1; dst_valid = 1; issue_dst = 2;
    #2;
    check("waw_hold", {15'd0, stall}, 16'h0001);
    step();
    issue = 1; src_b = 2; use_b = 1;
    #2;
    check("rawb_stall", {15'd0, stall}, 16'h0001);

    // build busy=0F then flush with issue and writeback
    do_issue(0);
    do_issue(1);
    do_issue(3);
    step();
    #2;
    check("pre_flush", {8'h00, busy}, 16'h000F);
    step();
    flush = 1; issue = 1; dst_valid = 1; issue_dst = 6;
    wr_en = 1; wr_addr = 7; wr_data = 16'h00AA;
    #2;
    check("flush_stall", {15'd0, stall}, 16'h0000);
    step();
    #2;
    check("flush_busy", {8'h00, busy}, 16'h0000);
    check("flush_wr_r7", r7, 16'h00AA);
    check("flush_keep_r3", r3, 16'hBEEF);

    // all busy, then async reset mid-cycle
    for (int k = 0; k < 8; k++) do_issue(k[2:0]);
    step();
    #2;
    check("all_busy", {8'h00, busy}, 16'h00FF);
    check("pre_rst_r7", r7, 16'h00AA);
    RSTN = 0;
    #1;
    check("arst_busy", {8'h00, busy}, 16'h0000);
    check("arst_r7", r7, 16'h0000);
    check("arst_r5", r5, 16'h0000);
    @(negedge CLK);
    RSTN = 1;
    #2;
    check("post_rst_busy", {8'h00, busy}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Eight-entry, 16-bit general register file with one write port and a pending-write scoreboard.
- Sits directly upstream of the operand-latch mux registers in the pipelined CPU.
- Outputs r0..r7 drive the operand mux data inputs d0..d7.
- Write-through bypass lets a mux register loading in the same cycle as writeback capture the new value.
- Scoreboard generates the decode stall for RAW and WAW hazards.

Parameters:
WIDTH, 16, data width of each register and of wr_data / r0..r7.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RSTN  input  1  asynchronous active-low reset.
wr_en  input  1  writeback strobe from final stage.
wr_addr  input  3  writeback destination register.
wr_data  input  WIDTH  writeback value.
issue  input  1  decode requests to issue an instruction this cycle.
issue_dst  input  3  destination register of issuing instruction.
dst_valid  input  1  issuing instruction writes a register.
src_a  input  3  operand A register index.
src_b  input  3  operand B register index.
use_a  input  1  instruction reads operand A.
use_b  input  1  instruction reads operand B.
flush  input  1  pipeline flush; discards all pending writes.
r0..r7  output  WIDTH each  register contents with write-through bypass.
busy  output  8  scoreboard, bit k = write to register k pending.
stall  output  1  issue must be held this cycle.

Behaviour:
- Reset (RSTN low, asynchronous): all eight registers = 0, busy = 8'h00. r0..r7 read 0 and stall = 0 while wr_en = 0 and issue = 0.
- Register write: at the rising edge with wr_en = 1, reg[wr_addr] <= wr_data. One write per cycle. No register is hardwired.
- Bypass (combinational): r_k = wr_data when wr_en && wr_addr == k, else reg[k]. Zero-cycle write-to-read visibility.
- Pending-clear term: clr_k = wr_en && wr_addr == k.
- Hazard terms (combinational):
  - haz_a = use_a && busy[src_a] && !clr_src_a
  - haz_b = use_b && busy[src_b] && !clr_src_b
  - haz_w = dst_valid && busy[issue_dst] && !clr_issue_dst
- stall = issue && !flush && (haz_a || haz_b || haz_w).
- fire = issue && !stall && !flush && dst_valid.
- Scoreboard update per bit k at each rising edge, in priority order:
  - flush = 1 -> busy[k] <= 0 (flush overrides issue and writeback).
  - fire && issue_dst == k -> busy[k] <= 1. A new pending write wins over a same-cycle clear of the old one.
  - clr_k -> busy[k] <= 0.
  - otherwise busy[k] holds.
- Flush does not affect register contents. A writeback arriving during or after a flush still writes its register.
- wr_en to a non-busy register is legal: data is written, busy is unchanged.
- Reset asserted mid-operation clears registers and busy immediately, independent of CLK.
- Latency: write visible on r_k in the same cycle (bypass) and from the register the cycle after. busy set visible the cycle after issue.

Test Plan:
- Reset then idle -> r0..r7 = 16'h0000, busy = 8'h00, stall = 0.
- wr_en = 1, wr_addr = 3, wr_data = 16'hBEEF for one cycle:
  - r3 = 16'hBEEF combinationally in that cycle and stays 16'hBEEF after the edge.
  - Other registers remain 0.
- Issue dst = 5, then the next cycle issue with src_a = 5, use_a = 1:
  - busy = 8'h20.
  - stall = 1 until the cycle wr_en = 1, wr_addr = 5, wr_data = 16'h1234. In that cycle stall = 0 and r5 = 16'h1234.
  - busy = 8'h00 afterwards.
- With busy[2] = 1, same cycle: wr_addr = 2 with wr_en = 1, and issue dst = 2 -> no stall, r2 = wr_data, busy[2] = 1 after the edge.
- busy = 8'h0F, flush = 1 with issue dst = 6 -> stall = 0, busy = 8'h00 after the edge.
- Pulse RSTN low mid-cycle with busy = 8'hFF and r7 = 16'h00AA -> busy = 0 and r7 = 0 immediately, without waiting for a clock edge.
